// File: rtl/pipelined_approx_adder_if.sv
// Handshake/data bundle for pipelined_approx_adder.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the adder (drives in_ready, out_valid, sum, carry)
// Signals: in_valid/in_ready, in1, in2, cin (operand side);
//          out_valid/out_ready, sum, carry (result side).
interface pipelined_approx_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output in_valid, in1, in2, cin, out_ready,
    input  in_ready, out_valid, sum, carry
  );

  modport slave (
    input  in_valid, in1, in2, cin, out_ready,
    output in_ready, out_valid, sum, carry
  );
endinterface

// File: rtl/pipelined_approx_adder.sv
// Pipelined chunked adder with a skewed carry pipeline and valid/ready flow.
// A WIDTH-bit add is split into STAGES chunks of CHUNK bits; stage k adds
// chunk k with the carry registered by stage k-1. Latency is STAGES cycles.
//
// Ports: clk, rst (async, active-high), bus (pipelined_approx_adder_if.slave):
//   in_valid/in_ready/in1/in2/cin in, out_valid/out_ready/sum/carry out.
//
// Optional macro APPROX_LOA_EN: the low APPROX_BITS of chunk 0 become a
// lower-part OR (no carry chain, cin ignored); carry into bit APPROX_BITS is
// in1[APPROX_BITS-1] & in2[APPROX_BITS-1]. Without it the add is exact.

// One chunk of generate/propagate ripple. The low LOA_BITS bits are OR-ed
// instead of added; the carry out of that region is the AND of its top bit.
module pipelined_approx_adder_chunk #(
  parameter int CHUNK    = 4,
  parameter int LOA_BITS = 0
)(
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out
);
  logic [CHUNK:0] cc;

  always_comb begin
    s     = '0;
    cc    = '0;
    cc[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      if (i < LOA_BITS) begin
        s[i]    = a[i] | b[i];
        cc[i+1] = a[i] & b[i];
      end else begin
        s[i]    = (a[i] ^ b[i]) ^ cc[i];
        cc[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cc[i]);
      end
    end
    c_out = cc[CHUNK];
  end
endmodule

module pipelined_approx_adder #(
  parameter int WIDTH       = 16,
  parameter int STAGES      = 4,
  parameter int APPROX_BITS = 4
)(
  input  logic                    clk,
  input  logic                    rst,
  pipelined_approx_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
`ifdef APPROX_LOA_EN
  localparam int LOA_BITS = APPROX_BITS;
`else
  localparam int LOA_BITS = 0;
`endif

  if (STAGES < 1 || (WIDTH % STAGES) != 0 || APPROX_BITS < 0 || APPROX_BITS > CHUNK)
  begin : g_bad_cfg
    $error("pipelined_approx_adder: illegal WIDTH/STAGES/APPROX_BITS");
  end

  // Single global enable: the whole pipe moves unless the result is blocked.
  logic              advance;
  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_pipe;

  assign vld_pipe     = {vld_q, bus.in_valid};
  assign advance      = ~vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready = advance;

  // Bubbles shift like real entries; nothing is collapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_q <= '0;
    else if (advance) vld_q <= vld_pipe[STAGES-1:0];
  end

  // Stage k word x: bits below LO hold finished sum chunks, bits from LO up
  // still hold operand A. Operand B is kept only for the chunks not yet added.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * CHUNK;

    logic [WIDTH-1:0]    x_in;
    logic [WIDTH-1:0]    x_q;
    logic [WIDTH-LO-1:0] b_in;
    logic                c_in;
    logic                c_q;
    logic [CHUNK-1:0]    cs;
    logic                co;

    if (k == 0) begin : g_first
      assign x_in = bus.in1;
      assign b_in = bus.in2;
`ifdef APPROX_LOA_EN
      assign c_in = 1'b0;
`else
      assign c_in = bus.cin;
`endif
    end else begin : g_next
      assign x_in = g_stg[k-1].x_q;
      assign b_in = g_stg[k-1].g_b.b_q;
      assign c_in = g_stg[k-1].c_q;
    end

    pipelined_approx_adder_chunk #(
      .CHUNK    (CHUNK),
      .LOA_BITS ((k == 0) ? LOA_BITS : 0)
    ) u_chunk (
      .a     (x_in[LO +: CHUNK]),
      .b     (b_in[CHUNK-1:0]),
      .c_in  (c_in),
      .s     (cs),
      .c_out (co)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x_q <= '0;
        c_q <= 1'b0;
      end else if (advance) begin
        x_q             <= x_in;
        x_q[LO +: CHUNK] <= cs;
        c_q             <= co;
      end
    end

    if (k < STAGES - 1) begin : g_b
      logic [WIDTH-LO-CHUNK-1:0] b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          b_q <= '0;
        else if (advance) b_q <= b_in[WIDTH-LO-1:CHUNK];
      end
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.sum       = g_stg[STAGES-1].x_q;
  assign bus.carry     = g_stg[STAGES-1].c_q;
endmodule

// File: tb/tb_pipelined_approx_adder.sv
// Self-checking bench for pipelined_approx_adder (WIDTH=16, STAGES=4).
// Directed steps plus a randomized stream scored against an arithmetic model.
module tb_pipelined_approx_adder;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int AB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_approx_adder_if #(.WIDTH(W)) bus();

  pipelined_approx_adder #(.WIDTH(W), .STAGES(S), .APPROX_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {carry,sum} from plain arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    int unsigned r;
`ifdef APPROX_LOA_EN
    int unsigned lo, hi, cu;
    lo = (a | b) & ((1 << AB) - 1);
    cu = (AB > 0) ? ((int'(a) >> (AB - 1)) & (int'(b) >> (AB - 1)) & 1) : 0;
    hi = (int'(a) >> AB) + (int'(b) >> AB) + cu;
    r  = (hi << AB) | lo;
    if (c) r = r;
`else
    r = int'(a) + int'(b) + int'(c);
`endif
    return r[W:0];
  endfunction

  // One clock: score any output transfer, record any input transfer.
  task automatic step();
    logic ix, ox;
    logic [W:0] res;
    #1;
    ix  = bus.in_valid & bus.in_ready;
    ox  = bus.out_valid & bus.out_ready;
    res = {bus.carry, bus.sum};
    if (ox) begin
      chk("out_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("result", res, exp_q.pop_front());
    end
    if (ix) exp_q.push_back(model(bus.in1, bus.in2, bus.cin));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W:0] expv);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in1 = a; bus.in2 = b; bus.cin = c;
    step();
    bus.in_valid = 1'b0;
    bus.in1 = W'($urandom); bus.in2 = W'($urandom); bus.cin = 1'($urandom);
    for (int i = 0; i < S - 1; i++) begin
      chk({tag, "_early"}, bus.out_valid, 0);
      step();
    end
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_value"}, {bus.carry, bus.sum}, expv);
    step();
  endtask

  initial begin
    int sent, n;
    logic acc;
    logic [W:0] held;

    bus.in_valid = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_carry", bus.carry, 0);
    chk("rst_in_ready", bus.in_ready, 1);

`ifdef APPROX_LOA_EN
    directed("exact1", 16'h1234, 16'h0FCD, 1'b1, 17'h021FD);
    directed("carryall", 16'hFFFF, 16'h0000, 1'b1, 17'h0FFFF);
    directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 17'h0FFFF);
    directed("loa", 16'h000F, 16'h0001, 1'b1, 17'h0000F);
`else
    directed("exact1", 16'h1234, 16'h0FCD, 1'b1, 17'h02202);
    directed("carryall", 16'hFFFF, 16'h0000, 1'b1, 17'h10000);
    directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    directed("loa", 16'h000F, 16'h0001, 1'b1, 17'h00011);
`endif
    chk("directed_drained", exp_q.size(), 0);

    // Random stream of 8 with a 3-cycle output stall mid-stream.
    sent = 0; n = 0; held = '0;
    bus.in1 = W'($urandom); bus.in2 = W'($urandom); bus.cin = 1'($urandom);
    while ((sent < 8 || exp_q.size() != 0) && n < 60) begin
      bus.out_ready = !(n >= 5 && n < 8);
      bus.in_valid  = (sent < 8);
      #1;
      if (!bus.out_ready) begin
        chk("stall_in_ready", bus.in_ready, 0);
        if (n > 5) chk("stall_hold", {bus.carry, bus.sum}, held);
        held = {bus.carry, bus.sum};
      end
      acc = bus.in_valid & bus.in_ready;
      step();
      if (acc) begin
        sent++;
        bus.in1 = W'($urandom); bus.in2 = W'($urandom); bus.cin = 1'($urandom);
      end
      n++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_sent", sent, 8);
    chk("stream_drained", exp_q.size(), 0);

    // Reset with two transactions in flight, the first one stalled at the output.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in1 = W'($urandom); bus.in2 = W'($urandom); bus.cin = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) step();
    chk("mid_valid_before", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_sum", bus.sum, 0);
    chk("mid_rst_carry", bus.carry, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("post_rst_quiet", bus.out_valid, 0);
      step();
    end

    // Pipe still works after the reset.
    directed("post_rst", 16'h8000, 16'h8000, 1'b1, model(16'h8000, 16'h8000, 1'b1));
    chk("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
